mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath, directly downstream of regfile.
- Consumes the two register read ports (dout_A = rs, dout_B = rt) and executes MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers that MFHI/MFLO read and MTHI/MTLO write.
- The pipeline stalls on busy.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 118 +++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, mult/div op encodings, mult/div FSM states.
package mips_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO; WIDTH+1 busy cycles per op.
// start is ignored while busy, as are MTHI/MTLO writes; divide by zero leaves HI/LO untouched.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state, state_nxt;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   divisor;
  logic               is_div, neg_q, neg_r, dbz;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy = (state != IDLE);

  assign abs_a = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? divisor : {WIDTH{1'b0}})};
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor};
  assign div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 6'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      divisor     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            acc     <= {{WIDTH{1'b0}}, abs_a};
            divisor <= abs_b;
            is_div  <= op[1];
            neg_q   <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r   <= op[0] & src_a[WIDTH-1];
            dbz     <= op[1] & (src_b == '0);
            cnt     <= '0;
          end
        end
        CALC: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (!dbz) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done        <= 1'b1;
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned results, collisions, reset.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        wr_hi, wr_lo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Stimulus only: pulse start at a negedge, then follow busy until it drops (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'hDEAD_BEEF;
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = OP_MULTU; src_a = '0; src_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int bc;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL multu_done got %b want 1", done); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult;
    int bc;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, bc);
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_err++; $display("FAIL mult_neg3x7 got %h want ffffffffffffffeb", {hi, lo}); end
    @(negedge clk);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, bc);
    n_cmp++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      n_err++; $display("FAIL mult_minxmin got %h want 4000000000000000", {hi, lo}); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int bc;
    run_op(OP_DIVU, 32'd100, 32'd7, bc);
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_err++; $display("FAIL divu_100_7 got hi=%h lo=%h want hi=2 lo=e", hi, lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL divu_dbz got %b want 0", div_by_zero); end
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc);
    n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_neg7_2 got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
    @(negedge clk);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, bc);
    n_cmp++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_7_neg2 got hi=%h lo=%h want hi=1 lo=fffffffd", hi, lo); end
    @(negedge clk);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    n_cmp++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin
      n_err++; $display("FAIL div_min_neg1 got hi=%h lo=%h want hi=0 lo=80000000", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_mtx_and_dbz;
    int bc;
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'h55, 32'h55}) begin
      n_err++; $display("FAIL mt_both got hi=%h lo=%h want 55/55", hi, lo); end
    wr_hi = 1'b1; wr_data = 32'h11;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
    @(negedge clk);
    wr_lo = 1'b0;
    run_op(OP_DIVU, 32'd5, 32'd0, bc);
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL dbz_busy_cycles got %0d want 33", bc); end
    n_cmp++; if ({done, div_by_zero} !== 2'b11) begin
      n_err++; $display("FAIL dbz_flag got done=%b dbz=%b want 1/1", done, div_by_zero); end
    n_cmp++; if ({hi, lo} !== {32'h11, 32'h22}) begin
      n_err++; $display("FAIL dbz_hilo got hi=%h lo=%h want 11/22", hi, lo); end
    @(negedge clk);
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_pulse got %b want 0", div_by_zero); end
  endtask

  task automatic test_collisions;
    int dones = 0;
    wr_hi = 1'b1; wr_data = 32'h77;
    @(negedge clk);
    wr_hi = 1'b0;
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    for (int i = 1; i <= 45; i++) begin
      start = (i == 1 || i == 20);
      src_a = 32'd9; src_b = 32'd9;
      wr_hi = (i == 5); wr_data = 32'hABCD;
      @(negedge clk);
      if (done) dones++;
      if (i == 5) begin
        n_cmp++; if (hi !== 32'h77) begin n_err++; $display("FAIL wr_hi_busy got %h want 77", hi); end
      end
    end
    start = 1'b0; wr_hi = 1'b0;
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL restart_dones got %0d want 1", dones); end
    n_cmp++; if ({hi, lo} !== {32'h0, 32'd15}) begin
      n_err++; $display("FAIL restart_result got hi=%h lo=%h want 0/f", hi, lo); end
    wr_lo = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_lo = 1'b0;
    n_cmp++; if (lo !== 32'h1234) begin n_err++; $display("FAIL wr_lo_idle got %h want 1234", lo); end
  endtask

  task automatic test_back_to_back;
    int bc;
    int n;
    run_op(OP_MULTU, 32'd2, 32'd3, bc);
    n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL b2b_first got %h want 6", lo); end
    start = 1'b1; op = OP_MULTU; src_a = 32'd4; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL b2b_edges got %0d want 34", n); end
    n_cmp++; if (lo !== 32'd20) begin n_err++; $display("FAIL b2b_second got %h want 14", lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int bc;
    start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF; src_b = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL midrst_hilo got %h want 0", {hi, lo}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_MULTU, 32'd6, 32'd7, bc);
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL midrst_latency got %0d want 33", bc); end
    n_cmp++; if ({hi, lo} !== {32'h0, 32'd42}) begin
      n_err++; $display("FAIL midrst_result got hi=%h lo=%h want 0/2a", hi, lo); end
  endtask

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_err++;
      $display("FAIL busy_done_overlap got busy=1 done=1 want not both");
    end
  end

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mtx_and_dbz();
    test_collisions();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
